// File: rtl/cic_frame_sched_pkg.sv
// Shared types and helpers for the CIC channel scheduler (package cic_package).
package cic_package;

  typedef enum logic {
    SCHED_IDLE = 1'b0,
    SCHED_SEND = 1'b1
  } sched_state_t;

  localparam int MASK_W = 32;
  localparam logic [5:0] NO_BIT = 6'd32;

  // Lowest set bit of mask at position >= from; NO_BIT when there is none.
  function automatic logic [5:0] next_set_bit(input logic [MASK_W-1:0] mask, input int from);
    logic [5:0] r;
    r = NO_BIT;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) r = 6'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/cic_frame_sched_hold.sv
// Per-channel holding register with pend flag, capture and drop detection.
module cic_frame_hold #(
  parameter int DW = 22
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dv,
  input  logic                 en,
  input  logic                 accept,
  input  logic signed [DW-1:0] din,
  output logic signed [DW-1:0] hold,
  output logic                 pend,
  output logic                 drop
);

  logic capture;

  // A word leaving this cycle frees the slot for a word arriving this cycle.
  assign capture = dv && en && (!pend || accept);
  assign drop    = dv && en && pend && !accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= 1'b0;
    end else if (capture) begin
      pend <= 1'b1;
    end else if (accept) begin
      pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) hold <= din;
  end

endmodule

// File: rtl/cic_frame_sched.sv
// Collects one sample per enabled CIC channel and streams them as an ordered frame.
// Optional CIC_FRAME_SCHED_OVF_CNT_EN adds a saturating overflow counter output ovf_cnt.
module cic_frame_sched
  import cic_package::*;
#(
  parameter  int NCH = 8,
  parameter  int DW  = 22,
  localparam int CW  = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH*DW-1:0]     ch_data,
  input  logic [NCH-1:0]        ch_dv,
  input  logic [NCH-1:0]        ch_en,
  output logic signed [DW-1:0]  m_data,
  output logic [CW-1:0]         m_ch,
  output logic                  m_first,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  frame_ovf,
  output logic                  busy
`ifdef CIC_FRAME_SCHED_OVF_CNT_EN
  ,
  output logic [15:0]           ovf_cnt
`endif
);

  sched_state_t          state, state_nxt;
  logic [NCH-1:0]        en_q, en_eff, accept, pend, drop;
  logic signed [DW-1:0]  hold_arr [NCH];
  logic [CW-1:0]         idx;
  logic [MASK_W-1:0]     en_q32, ch_en32;
  logic [5:0]            first_bit, nxt_bit, start_bit;
  logic                  frame_rdy, send, beat_acc, ovf_q;

  always_comb begin
    en_q32            = '0;
    en_q32[NCH-1:0]   = en_q;
    ch_en32           = '0;
    ch_en32[NCH-1:0]  = ch_en;
  end

  assign first_bit = next_set_bit(en_q32, 0);
  assign nxt_bit   = next_set_bit(en_q32, int'(idx) + 1);
  assign start_bit = next_set_bit(ch_en32, 0);

  assign send      = (state == SCHED_SEND);
  assign frame_rdy = (|ch_en) && ((pend & ch_en) == ch_en);
  assign beat_acc  = send && m_ready;
  // Mid-frame captures follow the frame's latched mask, not the live one.
  assign en_eff    = send ? en_q : ch_en;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign accept[c] = beat_acc && (idx == CW'(c));

    cic_frame_hold #(.DW(DW)) u_hold (
      .clk    (clk),
      .reset  (reset),
      .dv     (ch_dv[c]),
      .en     (en_eff[c]),
      .accept (accept[c]),
      .din    (ch_data[c*DW +: DW]),
      .hold   (hold_arr[c]),
      .pend   (pend[c]),
      .drop   (drop[c])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) state <= SCHED_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SCHED_IDLE: if (frame_rdy) state_nxt = SCHED_SEND;
      SCHED_SEND: if (beat_acc && (nxt_bit == NO_BIT)) state_nxt = SCHED_IDLE;
      default:    state_nxt = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q  <= '0;
      idx   <= '0;
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= |drop;
      if ((state == SCHED_IDLE) && frame_rdy) begin
        en_q <= ch_en;
        idx  <= start_bit[CW-1:0];
      end else if (beat_acc && (nxt_bit != NO_BIT)) begin
        idx <= nxt_bit[CW-1:0];
      end
    end
  end

  // Outputs derive from registered state only, so they hold steady under backpressure.
  always_comb begin
    m_valid = send;
    busy    = send;
    m_ch    = '0;
    m_data  = '0;
    m_first = 1'b0;
    m_last  = 1'b0;
    if (send) begin
      m_ch    = idx;
      m_data  = hold_arr[idx];
      m_first = (6'(idx) == first_bit);
      m_last  = (nxt_bit == NO_BIT);
    end
  end

  assign frame_ovf = ovf_q;

`ifdef CIC_FRAME_SCHED_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)                               ovf_cnt_q <= '0;
    else if (ovf_q && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_q <= ovf_cnt_q + 16'd1;
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_cic_frame_sched.sv
// Directed bench for cic_frame_sched (ovf_cnt checks when CIC_FRAME_SCHED_OVF_CNT_EN is defined).
module tb_cic_frame_sched;
  localparam int NCH = 8;
  localparam int DW  = 22;
  localparam int CW  = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NCH*DW-1:0]    ch_data;
  logic [NCH-1:0]       ch_dv, ch_en;
  logic signed [DW-1:0] m_data;
  logic [CW-1:0]        m_ch;
  logic                 m_first, m_last, m_valid, m_ready, frame_ovf, busy;
`ifdef CIC_FRAME_SCHED_OVF_CNT_EN
  logic [15:0]          ovf_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cic_frame_sched #(.NCH(NCH), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .ch_data   (ch_data),
    .ch_dv     (ch_dv),
    .ch_en     (ch_en),
    .m_data    (m_data),
    .m_ch      (m_ch),
    .m_first   (m_first),
    .m_last    (m_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .frame_ovf (frame_ovf),
    .busy      (busy)
`ifdef CIC_FRAME_SCHED_OVF_CNT_EN
    ,
    .ovf_cnt   (ovf_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int c, input int val);
    ch_data[c*DW +: DW] = DW'(val);
  endtask

  task automatic chk_beat(input string tag, input int ch, input int data, input bit first, input bit last);
    chk({tag, "_valid"}, 32'(m_valid), 32'd1);
    chk({tag, "_ch"},    32'(m_ch), 32'(ch));
    chk({tag, "_data"},  32'(m_data), 32'(data));
    chk({tag, "_first"}, 32'(m_first), 32'(first));
    chk({tag, "_last"},  32'(m_last), 32'(last));
  endtask

  int sparse_ch [3] = '{2, 5, 7};

  initial begin
    reset = 1'b1; ch_data = '0; ch_dv = '0; ch_en = '0; m_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_first", 32'(m_first), 0);
    chk("rst_last",  32'(m_last), 0);
    chk("rst_ovf",   32'(frame_ovf), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_data",  32'(m_data), 0);
    chk("rst_ch",    32'(m_ch), 0);
    reset = 1'b0;
    tick();

    // Full frame
    ch_en = 8'hFF; m_ready = 1'b1;
    for (int c = 0; c < NCH; c++) set_data(c, c * 100);
    ch_dv = 8'hFF;
    tick();
    ch_dv = '0;
    chk("full_lat_valid", 32'(m_valid), 0);
    tick();
    for (int b = 0; b < NCH; b++) begin
      chk_beat("full", b, b * 100, b == 0, b == 7);
      tick();
    end
    chk("full_end_valid", 32'(m_valid), 0);
    chk("full_end_busy",  32'(busy), 0);

    // Sparse mask; channel 0 pulses but is disabled
    ch_en = 8'b1010_0100;
    for (int c = 0; c < NCH; c++) set_data(c, 1000 + c);
    ch_dv = 8'hFF;
    tick();
    ch_dv = '0;
    tick();
    for (int b = 0; b < 3; b++) begin
      chk_beat("sparse", sparse_ch[b], 1000 + sparse_ch[b], b == 0, b == 2);
      tick();
    end
    chk("sparse_end_valid", 32'(m_valid), 0);

    // Single-bit mask
    ch_en = 8'h10; set_data(4, 68); ch_dv = 8'h10;
    tick();
    ch_dv = '0;
    tick();
    chk_beat("single", 4, 68, 1'b1, 1'b1);
    tick();
    chk("single_end_valid", 32'(m_valid), 0);

    // Backpressure on beat 3 with drop on ch5 and recapture on ch1
    ch_en = 8'hFF;
    for (int c = 0; c < NCH; c++) set_data(c, c * 10 + 1);
    ch_dv = 8'hFF;
    tick();
    ch_dv = '0;
    tick();
    for (int b = 0; b < 3; b++) begin
      chk_beat("bp_pre", b, b * 10 + 1, b == 0, 1'b0);
      tick();
    end
    m_ready = 1'b0;
    set_data(5, 999); set_data(1, 555); ch_dv = 8'h22;
    tick();
    ch_dv = '0;
    chk("bp_ovf_pulse", 32'(frame_ovf), 1);
    chk_beat("bp_stall0", 3, 31, 1'b0, 1'b0);
    for (int s = 1; s < 5; s++) begin
      tick();
      chk_beat("bp_stall", 3, 31, 1'b0, 1'b0);
      if (s == 1) chk("bp_ovf_clear", 32'(frame_ovf), 0);
    end
    m_ready = 1'b1;
    for (int b = 3; b < NCH; b++) begin
      chk_beat("bp_post", b, b * 10 + 1, 1'b0, b == 7);
      tick();
    end
    chk("bp_end_valid", 32'(m_valid), 0);

    // Next frame: ch1 already holds 555; same-cycle accept/capture on ch4
    for (int c = 0; c < NCH; c++) if (c != 1) set_data(c, 200 + c);
    ch_dv = 8'hFD;
    tick();
    ch_dv = '0;
    tick();
    for (int b = 0; b < 4; b++) begin
      chk_beat("acc_pre", b, (b == 1) ? 555 : 200 + b, b == 0, 1'b0);
      tick();
    end
    chk_beat("acc_a", 4, 204, 1'b0, 1'b0);
    set_data(4, 2827); ch_dv = 8'h10;
    tick();
    ch_dv = '0;
    chk("acc_no_ovf", 32'(frame_ovf), 0);
    for (int b = 5; b < NCH; b++) begin
      chk_beat("acc_post", b, 200 + b, 1'b0, b == 7);
      tick();
    end
    chk("acc_end_valid", 32'(m_valid), 0);

    // Following frame carries B on ch4; reset lands on beat 4
    for (int c = 0; c < NCH; c++) if (c != 4) set_data(c, 300 + c);
    ch_dv = 8'hEF;
    tick();
    ch_dv = '0;
    tick();
    for (int b = 0; b < 4; b++) begin
      chk_beat("b_frame", b, 300 + b, b == 0, 1'b0);
      tick();
    end
    chk_beat("b_ch4", 4, 2827, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_valid", 32'(m_valid), 0);
    chk("rstmid_busy",  32'(busy), 0);
    // Only ch0..4 refilled; stale ch5..7 pend would wrongly start a frame
    for (int c = 0; c < NCH; c++) set_data(c, c * 100 + 7);
    ch_dv = 8'h1F;
    tick();
    ch_dv = '0;
    tick();
    chk("rstmid_pend_cleared", 32'(m_valid), 0);
    ch_dv = 8'hE0;
    tick();
    ch_dv = '0;
    tick();
    for (int b = 0; b < NCH; b++) begin
      chk_beat("fresh", b, b * 100 + 7, b == 0, b == 7);
      tick();
    end
    chk("fresh_end_valid", 32'(m_valid), 0);

    // Three consecutive drops on ch0 in IDLE
    set_data(0, 1); ch_dv = 8'h01;
    tick();
    chk("drop_first_capture", 32'(frame_ovf), 0);
    for (int d = 0; d < 3; d++) begin
      tick();
      chk("drop_pulse", 32'(frame_ovf), 1);
    end
    ch_dv = '0;
    tick();
    chk("drop_end", 32'(frame_ovf), 0);
`ifdef CIC_FRAME_SCHED_OVF_CNT_EN
    chk("ovf_cnt_3", 32'(ovf_cnt), 3);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("drop_rst_ovf", 32'(frame_ovf), 0);
`ifdef CIC_FRAME_SCHED_OVF_CNT_EN
    chk("ovf_cnt_rst", 32'(ovf_cnt), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cic_frame_sched.md
# cic_frame_sched

Channel scheduler for the microphone-array decimation bank. Collects one output sample per enabled channel from N parallel CIC decimators, each with its own `out_dv`. Once every enabled channel holds a fresh sample, it emits them as one ordered frame on a valid/ready stream to the downstream packetizer or FIFO. It flags samples lost when a decimator produces faster than the stream drains.

## Interface
- `NCH`, default 8: number of decimator channels; 2..32.
- `DW`, default 22: sample width; equals decimator output width.
- `CW`, default `$clog2(NCH)`: channel index width; derived, not overridden.

- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `ch_data`  in  NCH*DW  packed decimator outputs; channel c at bits [c*DW +: DW]; signed.
- `ch_dv`  in  NCH  per-channel sample-valid, one-cycle pulses.
- `ch_en`  in  NCH  channel enable mask; sampled only at frame start.
- `m_data`  out  DW  sample of current beat.
- `m_ch`  out  CW  channel index of current beat.
- `m_first`  out  1  high on the first beat of a frame.
- `m_last`  out  1  high on the last beat of a frame.
- `m_valid`  out  1  beat valid.
- `m_ready`  in  1  downstream accept.
- `frame_ovf`  out  1  one-cycle pulse when a sample is dropped.
- `busy`  out  1  high while in SEND.

## Operation
- Each channel has a holding register `hold[c]` (DW bits) and a `pend[c]` bit.
- Capture rule: `ch_dv[c]` with `ch_en[c]`=1 and `pend[c]`=0 loads `hold[c]` and sets `pend[c]`.
- `ch_dv[c]` with `ch_en[c]`=0 is ignored in IDLE.
- Drop rule: `ch_dv[c]` while `pend[c]`=1 and channel c not being accepted in the same cycle:
  - new sample discarded, old one kept;
  - `frame_ovf` pulses.
  - Multiple drops in one cycle give a single pulse.
- Simultaneous accept and `ch_dv` on the same channel: old word goes out, new word captured, `pend` stays 1, no overflow.
- State machine:
  - **IDLE → SEND** when `ch_en` != 0 and `(pend & ch_en) == ch_en`.
    - On that edge, latch `ch_en` into `en_q`.
    - On that edge, load `idx` with the lowest set bit of `ch_en`.
  - **SEND**: presents `hold[idx]`.
    - On `m_valid && m_ready`: clear `pend[idx]`, then advance `idx` to the next set bit of `en_q` above it.
    - Acceptance of the highest set bit of `en_q` → IDLE.
  - `ch_en` all-zero: remain in IDLE; nothing is captured.
- During SEND, channels are captured using `en_q`, not live `ch_en`.
- A channel already sent in the current frame may capture its next sample immediately.
- `m_first` = SEND and `idx` is the lowest bit of `en_q`; `m_last` = SEND and `idx` is the highest bit.
- A single-channel mask gives `m_first` = `m_last` = 1 on one beat.
- `m_data`, `m_ch`, `m_first`, `m_last` are held stable while `m_valid` && !`m_ready`.

## Timing
- Reset values:
  - `m_valid`, `m_first`, `m_last`, `frame_ovf`, `busy` = 0;
  - `m_data` = 0, `m_ch` = 0;
  - all `pend` = 0, state IDLE.
- `reset` asserted mid-frame aborts the frame: the next cycle has `m_valid` = 0 and all pending samples are discarded.
- Latency: last required `ch_dv` sampled at edge k → `pend` complete after k → SEND after edge k+1 → `m_valid` high in the cycle after edge k+1 (2 cycles).
- Throughput: one beat per cycle with `m_ready` held high.
- With `m_ready` held high, IDLE occupies at least one cycle between frames.
- `frame_ovf` is registered: it is high in the cycle after the offending `ch_dv`.

## Configuration
- `CIC_FRAME_SCHED_OVF_CNT_EN`:
  - **Defined**: adds output `ovf_cnt [15:0]`, a saturating count of `frame_ovf` pulses.
    - Reset to 0.
    - Holds at 16'hFFFF once reached.
  - **Undefined**: port and counter absent; `frame_ovf` behaviour unchanged.

## Structure
- Shared package `cic_package` holds:
  - the state enum (`SCHED_IDLE`, `SCHED_SEND`);
  - the function `next_set_bit(mask, from)` used for `idx` advance and for first/last detection.
- One sub-module, `cic_frame_hold`: per-channel holding register with pend/capture/drop logic, instantiated NCH times in a generate loop.
- The scheduler FSM and output mux stay in the top.

## Test plan
- **Full frame**: NCH=8, all enabled, simultaneous `ch_dv`=8'hFF with data c*100, `m_ready`=1.
  - `m_valid` 2 cycles later.
  - 8 consecutive beats, `m_ch` 0..7, data 0,100..700.
  - `m_first` on beat 0, `m_last` on beat 7.
- **Sparse mask**: `ch_en`=8'b1010_0100.
  - Beats on channels 2, 5, 7 only.
  - `ch_dv[0]` ignored, never emitted.
  - Single-bit mask 8'h10 → one beat with `m_first` = `m_last` = 1.
- **Backpressure**: `m_ready` low for 5 cycles on beat 3.
  - Outputs stable throughout.
  - Second `ch_dv[5]` during the stall → `frame_ovf` pulse, original channel 5 sample emitted.
  - Second `ch_dv[1]` (already sent) → no overflow, captured for next frame.
- **Same-cycle accept and capture**: `ch_dv[4]` with value B coincides with acceptance of channel 4 holding value A.
  - A emitted, no `frame_ovf`.
  - Next frame emits B for channel 4.
- **Reset mid-frame**: `reset` for 1 cycle at beat 4.
  - Next cycle `m_valid` = 0, `busy` = 0.
  - A fresh full frame then emits all 8 beats from `m_ch`=0.
- **Overflow counter (macro defined)**: force 3 drops → `ovf_cnt`=3; reset → 0.
